line_cache_sched: RTL and testbench

// - Schedules the 4-bank GBA line cache feeding the upscaler's 3x3 smoothing window.
// - Capture side fills one bank per GBA line; display side consumes via nextLine/cacheUpdate.
// - Outputs writer bank, registered prev/cur/next bank selects, sameLine and newFrame for the upscaler.
// - Flags overflow (writer lapping reader) and underrun (reader ahead of writer).

---
 rtl/line_cache_sched.sv | 151 +++++++++++++++
 tb/tb_line_cache_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/line_cache_sched.sv
// Line cache scheduler: tracks capture/display line positions over a 4-bank GBA line cache
// and publishes the upscaler's prev/cur/next bank window. Optional drop counter: LINE_CACHE_STATS_EN.
module line_cache_sched #(
  parameter int LINES = 160,
  parameter int BANKS = 4
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic        wrFrameStart,
  input  logic        wrLineDone,
  input  logic        nextLine,
  input  logic        cacheUpdate,
  output logic [1:0]  wrBank,
  output logic [1:0]  prevBank,
  output logic [1:0]  curBank,
  output logic [1:0]  nextBank,
  output logic        sameLine,
  output logic        newFrame,
  output logic        overflow,
  output logic        underrun,
  output logic [15:0] dropCnt
);

  localparam int LW = $clog2(LINES + 1);
  localparam int BW = $clog2(BANKS);
  typedef logic [LW-1:0] line_t;
  localparam line_t LAST = line_t'(LINES - 1);
  localparam line_t LMAX = line_t'(LINES);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t     state_q, state_d;
  line_t      wrLine_q, wrLine_d;
  line_t      rdLine_q, rdLine_d;
  logic       newFrame_q, newFrame_d;
  logic       overflow_q, overflow_d;
  logic       underrun_q, underrun_d;
  logic [5:0] banks_q, banks_d;
  logic       ovf_evt;
  logic       adv_legal;
  logic       prime_done;
  line_t      win;
  line_t      wr_n;

  // Bank window {prev, cur, next} for a display line, replicating cur at frame edges.
  function automatic logic [5:0] banks_for(input line_t r);
    logic [BW-1:0] c, p, n;
    c = r[BW-1:0];
    p = (r == '0)   ? c : c - 1'b1;
    n = (r == LAST) ? c : c + 1'b1;
    return {p, c, n};
  endfunction

  always_comb begin
    win        = (rdLine_q <= LAST - line_t'(2)) ? rdLine_q + line_t'(2) : LAST;
    adv_legal  = (state_q == RUN) && (rdLine_q < LAST) && (wrLine_q > win);
    prime_done = (state_q == PRIME) && (wrLine_q >= line_t'(2));
    wr_n       = wrLine_q + line_t'(1);
  end

  always_comb begin
    state_d    = state_q;
    wrLine_d   = wrLine_q;
    rdLine_d   = rdLine_q;
    newFrame_d = newFrame_q;
    overflow_d = overflow_q;
    underrun_d = underrun_q;
    banks_d    = banks_q;
    ovf_evt    = 1'b0;
    if (wrFrameStart) begin
      state_d    = PRIME;
      wrLine_d   = '0;
      rdLine_d   = '0;
      newFrame_d = 1'b0;
      overflow_d = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (nextLine && adv_legal) begin
        rdLine_d   = rdLine_q + line_t'(1);
        newFrame_d = 1'b0;
      end else if (nextLine && state_q == RUN) begin
        underrun_d = 1'b1;
      end
      // Overflow is judged against the reader position after any same-cycle advance.
      if (wrLineDone && state_q != IDLE && wrLine_q < LMAX) begin
        wrLine_d = wr_n;
        if (wr_n < LMAX && {1'b0, wr_n} >= {1'b0, rdLine_d} + (LW+1)'(3)) begin
          overflow_d = 1'b1;
          ovf_evt    = 1'b1;
        end
      end
      if (prime_done) begin
        state_d    = RUN;
        newFrame_d = 1'b1;
      end
    end
    if (cacheUpdate || (prime_done && !wrFrameStart))
      banks_d = banks_for(rdLine_d);
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      state_q    <= IDLE;
      wrLine_q   <= '0;
      rdLine_q   <= '0;
      newFrame_q <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      banks_q    <= '0;
    end else begin
      state_q    <= state_d;
      wrLine_q   <= wrLine_d;
      rdLine_q   <= rdLine_d;
      newFrame_q <= newFrame_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      banks_q    <= banks_d;
    end
  end

`ifdef LINE_CACHE_STATS_EN
  logic [15:0] dropCnt_q, dropCnt_d;

  always_comb begin
    dropCnt_d = dropCnt_q;
    if (ovf_evt && dropCnt_q != 16'hFFFF)
      dropCnt_d = dropCnt_q + 16'd1;
  end

  always_ff @(posedge pxlClk) begin
    if (rst) dropCnt_q <= '0;
    else     dropCnt_q <= dropCnt_d;
  end

  assign dropCnt = dropCnt_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_evt;
  assign dropCnt    = 16'h0000;
`endif

  assign wrBank   = wrLine_q[BW-1:0];
  assign prevBank = banks_q[5:4];
  assign curBank  = banks_q[3:2];
  assign nextBank = banks_q[1:0];
  assign sameLine = !adv_legal;
  assign newFrame = newFrame_q;
  assign overflow = overflow_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_line_cache_sched.sv
// Directed bench for line_cache_sched: priming, advancing, frame edges, overflow/underrun, restart, reset.
module tb_line_cache_sched;

  logic        pxlClk = 1'b0;
  logic        rst = 1'b1;
  logic        wrFrameStart = 1'b0;
  logic        wrLineDone = 1'b0;
  logic        nextLine = 1'b0;
  logic        cacheUpdate = 1'b0;
  logic [1:0]  wrBank, prevBank, curBank, nextBank;
  logic        sameLine, newFrame, overflow, underrun;
  logic [15:0] dropCnt;

  int n_checks = 0;
  int n_errors = 0;

  line_cache_sched dut (
    .pxlClk(pxlClk), .rst(rst), .wrFrameStart(wrFrameStart), .wrLineDone(wrLineDone),
    .nextLine(nextLine), .cacheUpdate(cacheUpdate), .wrBank(wrBank), .prevBank(prevBank),
    .curBank(curBank), .nextBank(nextBank), .sameLine(sameLine), .newFrame(newFrame),
    .overflow(overflow), .underrun(underrun), .dropCnt(dropCnt)
  );

  always #5 pxlClk = ~pxlClk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pxlClk);
    #1;
  endtask

  function automatic int win3(input int p, input int c, input int n);
    return p * 16 + c * 4 + n;
  endfunction

  function automatic int drop_exp(input int n);
`ifdef LINE_CACHE_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  int win_obs;
  always_comb win_obs = {28'd0, prevBank, curBank, nextBank};

  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_win", win_obs, 0);
    chk("rst_wrbank", wrBank, 0);
    chk("rst_same", sameLine, 1);
    chk("rst_newframe", newFrame, 0);
    chk("rst_flags", {overflow, underrun}, 0);
    chk("rst_drop", dropCnt, 0);

    // Frame A: prime with two lines
    wrFrameStart = 1'b1; step(); wrFrameStart = 1'b0;
    chk("prime_same", sameLine, 1);
    wrLineDone = 1'b1; step(); step(); wrLineDone = 1'b0;
    step();
    chk("run_newframe", newFrame, 1);
    chk("run_win", win_obs, win3(0, 0, 1));
    chk("run_same", sameLine, 1);
    chk("run_wrbank", wrBank, 2);
    chk("run_ovf0", overflow, 0);

    // Advance not yet legal: underrun, window unchanged
    nextLine = 1'b1; cacheUpdate = 1'b1; step(); nextLine = 1'b0; cacheUpdate = 1'b0;
    chk("udr_flag", underrun, 1);
    chk("udr_win", win_obs, win3(0, 0, 1));
    chk("udr_newframe", newFrame, 1);

    // Third line lands two lines ahead of a reader still on 0
    wrLineDone = 1'b1; step(); wrLineDone = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", dropCnt, drop_exp(1));
    chk("ovf_wrbank", wrBank, 3);
    chk("ovf_same", sameLine, 0);

    nextLine = 1'b1; cacheUpdate = 1'b1; step(); nextLine = 1'b0; cacheUpdate = 1'b0;
    chk("adv1_win", win_obs, win3(0, 1, 2));
    chk("adv1_newframe", newFrame, 0);
    chk("adv1_same", sameLine, 1);

    // Frame B: full capture (one extra done is ignored), reader to line 40
    wrFrameStart = 1'b1; step(); wrFrameStart = 1'b0;
    chk("fb_flags", {overflow, underrun}, 0);
    wrLineDone = 1'b1;
    for (int i = 0; i < 161; i++) step();
    wrLineDone = 1'b0;
    chk("fb_wrbank", wrBank, 0);
    chk("fb_drop", dropCnt, drop_exp(158));
    chk("fb_same", sameLine, 0);
    nextLine = 1'b1;
    for (int i = 0; i < 40; i++) step();
    nextLine = 1'b0;
    cacheUpdate = 1'b1; step(); cacheUpdate = 1'b0;
    chk("fb_win40", win_obs, win3(3, 0, 1));

    // Restart mid-frame with a simultaneous line done (ignored)
    wrFrameStart = 1'b1; wrLineDone = 1'b1; step(); wrFrameStart = 1'b0; wrLineDone = 1'b0;
    chk("rs_same", sameLine, 1);
    chk("rs_newframe", newFrame, 0);
    chk("rs_flags", {overflow, underrun}, 0);
    chk("rs_wrbank", wrBank, 0);
    cacheUpdate = 1'b1; step(); cacheUpdate = 1'b0;
    chk("rs_win", win_obs, win3(0, 0, 1));

    // Frame C: full capture then run reader to the last line
    wrLineDone = 1'b1;
    for (int i = 0; i < 160; i++) step();
    wrLineDone = 1'b0;
    chk("fc_drop", dropCnt, drop_exp(315));
    nextLine = 1'b1;
    for (int i = 0; i < 158; i++) step();
    cacheUpdate = 1'b1; step(); nextLine = 1'b0; cacheUpdate = 1'b0;
    chk("end_win", win_obs, win3(2, 3, 3));
    chk("end_same", sameLine, 1);
    chk("end_udr0", underrun, 0);
    nextLine = 1'b1; cacheUpdate = 1'b1; step(); nextLine = 1'b0; cacheUpdate = 1'b0;
    chk("end_udr1", underrun, 1);
    chk("end_hold", win_obs, win3(2, 3, 3));

    // Reset mid-operation with a pulse in flight
    rst = 1'b1; nextLine = 1'b1; step(); rst = 1'b0; nextLine = 1'b0;
    chk("mr_win", win_obs, 0);
    chk("mr_flags", {overflow, underrun, newFrame}, 0);
    chk("mr_same", sameLine, 1);
    chk("mr_drop", dropCnt, 0);
    chk("mr_wrbank", wrBank, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
